// File: rtl/udc_pkg.sv
// Shared types and step arithmetic for the swap up/down counter.
// Build option: UDC_SATURATE_EN (defined: channels hold at their limit
// instead of wrapping; undefined: modular wrap).
package udc_pkg;

    // Internal arithmetic width; wide enough for any channel up to 32 bits
    // plus one guard bit for the compare/increment.
    localparam int UDC_CALC_W = 33;

    typedef enum logic {MODE_NORMAL, MODE_SWAPPED} mode_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    typedef struct packed {
        logic [UDC_CALC_W-1:0] value;
        logic                  wrap;
    } step_t;

    // Next value of one channel after a single step, plus the limit flag.
    function automatic step_t udc_next(
        input logic [UDC_CALC_W-1:0] value,
        input dir_t                  dir,
        input logic [UDC_CALC_W-1:0] max_count
    );
        step_t r;
        r.value = value;
        r.wrap  = 1'b0;
        if (dir == DIR_UP) begin
            if (value >= max_count) begin
`ifdef UDC_SATURATE_EN
                r.value = max_count;
`else
                r.value = '0;
`endif
                r.wrap  = 1'b1;
            end else begin
                r.value = value + 1'b1;
            end
        end else begin
            if (value == '0) begin
`ifdef UDC_SATURATE_EN
                r.value = '0;
`else
                r.value = max_count;
`endif
                r.wrap  = 1'b1;
            end else begin
                r.value = value - 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/udc_channel.sv
// One counter channel: load, step in the given direction, registered
// wrap/limit pulse. Build option UDC_SATURATE_EN is handled in udc_pkg.
module udc_channel #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             step_en,
    input  udc_pkg::dir_t    dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] reset_value,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    import udc_pkg::*;

    localparam logic [UDC_CALC_W-1:0] MAX_EXT = UDC_CALC_W'(MAX_COUNT);

    logic [WIDTH-1:0] count_reg;
    logic             wrap_reg;
    step_t            nxt;
    logic             unused_hi;

    // Candidate next value computed with a guard bit so the limit compare
    // cannot overflow even when MAX_COUNT is the all-ones value.
    always_comb begin
        nxt = udc_next(UDC_CALC_W'(count_reg), dir, MAX_EXT);
    end

    assign unused_hi = ^nxt.value[UDC_CALC_W-1:WIDTH];

    // Count register: load wins over step; wrap pulse only on a real step.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_reg <= reset_value;
            wrap_reg  <= 1'b0;
        end else if (load) begin
            count_reg <= load_value;
            wrap_reg  <= 1'b0;
        end else if (step_en) begin
            count_reg <= nxt.value[WIDTH-1:0];
            wrap_reg  <= nxt.wrap;
        end else begin
            wrap_reg  <= 1'b0;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;

endmodule

// File: rtl/swap_updown_counter.sv
// Two complementary counter channels whose directions reverse on each
// rising edge of Swap. Build option UDC_SATURATE_EN: hold at limits.
module swap_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Swap,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] UpCountS,
    output logic [WIDTH-1:0] DownCountS,
    output logic             Direction,
    output logic             UpWrap,
    output logic             DownWrap
);
    import udc_pkg::*;

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

    logic             swap_q_reg;
    mode_t            mode_reg;
    logic             swap_edge;
    logic [WIDTH-1:0] load_clamped;

    // Per-channel wiring: index 0 is channel A (UpCountS), 1 is channel B.
    dir_t             ch_dir    [2];
    logic [WIDTH-1:0] ch_load   [2];
    logic [WIDTH-1:0] ch_rst    [2];
    logic [WIDTH-1:0] ch_count  [2];
    logic             ch_wrap   [2];

    assign swap_edge = Swap & ~swap_q_reg;

    // Swap edge detector and mode FSM; runs regardless of Enable/Load.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            swap_q_reg <= 1'b0;
            mode_reg   <= MODE_NORMAL;
        end else begin
            swap_q_reg <= Swap;
            if (swap_edge) begin
                case (mode_reg)
                    MODE_NORMAL: mode_reg <= MODE_SWAPPED;
                    default:     mode_reg <= MODE_NORMAL;
                endcase
            end
        end
    end

    // Clamp the load value into range; channel B gets the complement.
    always_comb begin
        load_clamped = LoadValue;
        if ({1'b0, LoadValue} > {1'b0, MAX_W}) begin
            load_clamped = MAX_W;
        end
    end

    assign ch_dir[0]  = (mode_reg == MODE_NORMAL) ? DIR_UP : DIR_DOWN;
    assign ch_dir[1]  = (mode_reg == MODE_NORMAL) ? DIR_DOWN : DIR_UP;
    assign ch_load[0] = load_clamped;
    assign ch_load[1] = MAX_W - load_clamped;
    assign ch_rst[0]  = '0;
    assign ch_rst[1]  = MAX_W;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            udc_channel #(
                .WIDTH     (WIDTH),
                .MAX_COUNT (MAX_COUNT)
            ) u_channel (
                .Clock       (Clock),
                .Reset       (Reset),
                .step_en     (Enable),
                .dir         (ch_dir[gi]),
                .load        (Load),
                .load_value  (ch_load[gi]),
                .reset_value (ch_rst[gi]),
                .count       (ch_count[gi]),
                .wrap        (ch_wrap[gi])
            );
        end
    endgenerate

    assign UpCountS   = ch_count[0];
    assign DownCountS = ch_count[1];
    assign UpWrap     = ch_wrap[0];
    assign DownWrap   = ch_wrap[1];
    assign Direction  = (mode_reg == MODE_SWAPPED);

endmodule
